// File: rtl/de2_70_cpu_oci_trace_capture.sv
// On-chip trace capture buffer for the CPU OCI debug path.
// Trace words are captured into a DEPTH-entry circular buffer while armed.
// When full, the buffer either drops new words or overwrites the oldest one.
// On test_ending it freezes and drains oldest-first through a valid/ready port,
// then raises test_has_ended until the next arm or reset.
module de2_70_cpu_oci_trace_capture #(
  parameter int DATA_W = 30,
  parameter int DEPTH  = 16,
  parameter int MODE   = 0,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              trc_valid,
  input  logic [DATA_W-1:0] trc_data,
  input  logic              test_ending,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  trc_count,
  output logic              overflow,
  output logic              test_has_ended,
  output logic [1:0]        state
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              mem_we;

  // Buffer is full when it holds DEPTH words; a write lands in memory unless
  // the buffer is full and stop policy discards it. arm outranks any write.
  always_comb begin
    full   = (trc_count == CNT_W'(DEPTH));
    mem_we = (state == ST_CAPTURE) && !arm && trc_valid && (!full || (MODE != 0));
  end

  // Read port shows the oldest unread word only while draining a non-empty buffer.
  always_comb begin
    rd_valid = (state == ST_DRAIN) && (trc_count != '0);
    rd_data  = rd_valid ? mem[rd_ptr] : '0;
  end

  // Trace storage is left unreset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr] <= trc_data;
    end
  end

  // Control: arm restarts capture from any state, otherwise capture words until
  // test_ending, then drain one word per accepted handshake until empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      trc_count      <= '0;
      overflow       <= 1'b0;
      test_has_ended <= 1'b0;
    end else if (arm) begin
      state          <= ST_CAPTURE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      trc_count      <= '0;
      overflow       <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      case (state)
        ST_CAPTURE: begin
          if (trc_valid) begin
            if (!full) begin
              wr_ptr    <= wr_ptr + PTR_W'(1);
              trc_count <= trc_count + CNT_W'(1);
            end else begin
              overflow <= 1'b1;
              if (MODE != 0) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                rd_ptr <= rd_ptr + PTR_W'(1);
              end
            end
          end
          if (test_ending) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (trc_count == '0) begin
            state          <= ST_DONE;
            test_has_ended <= 1'b1;
          end else if (rd_ready) begin
            rd_ptr    <= rd_ptr + PTR_W'(1);
            trc_count <= trc_count - CNT_W'(1);
            if (trc_count == CNT_W'(1)) begin
              state          <= ST_DONE;
              test_has_ended <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_de2_70_cpu_oci_trace_capture.sv
// Bench for the OCI trace capture buffer: one stop-policy and one wrap-policy
// instance (DEPTH=4) share stimulus. A queue-based reference model predicts the
// buffer contents; a negedge monitor pops expected words as the DUTs hand them out.
module tb_de2_70_cpu_oci_trace_capture;

  localparam int DW  = 30;
  localparam int DEP = 4;
  localparam int CW  = $clog2(DEP + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          arm;
  logic          trc_valid;
  logic [DW-1:0] trc_data;
  logic          test_ending;
  logic          rd_ready;

  logic          rd_valid_o [2];
  logic [DW-1:0] rd_data_o  [2];
  logic [CW-1:0] count_o    [2];
  logic          ovf_o      [2];
  logic          ended_o    [2];
  logic [1:0]    state_o    [2];

  int n_checks = 0;
  int n_errors = 0;

  // reference model: index 0 = stop policy, 1 = wrap policy
  logic [DW-1:0] mbuf  [2][$];
  logic [DW-1:0] exp_q [2][$];
  int            phase [2] = '{0, 0};
  int            mcnt  [2] = '{0, 0};
  int            movf  [2] = '{0, 0};
  int            mend  [2] = '{0, 0};

  always #5 clk = ~clk;

  de2_70_cpu_oci_trace_capture #(.DATA_W(DW), .DEPTH(DEP), .MODE(0)) u_stop (
    .clk(clk), .reset_n(reset_n), .arm(arm), .trc_valid(trc_valid), .trc_data(trc_data),
    .test_ending(test_ending), .rd_ready(rd_ready), .rd_valid(rd_valid_o[0]),
    .rd_data(rd_data_o[0]), .trc_count(count_o[0]), .overflow(ovf_o[0]),
    .test_has_ended(ended_o[0]), .state(state_o[0])
  );

  de2_70_cpu_oci_trace_capture #(.DATA_W(DW), .DEPTH(DEP), .MODE(1)) u_wrap (
    .clk(clk), .reset_n(reset_n), .arm(arm), .trc_valid(trc_valid), .trc_data(trc_data),
    .test_ending(test_ending), .rd_ready(rd_ready), .rd_valid(rd_valid_o[1]),
    .rd_data(rd_data_o[1]), .trc_count(count_o[1]), .overflow(ovf_o[1]),
    .test_has_ended(ended_o[1]), .state(state_o[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic v, input logic [DW-1:0] d,
                               input logic e, input logic r);
    @(posedge clk);
    #1;
    arm         = a;
    trc_valid   = v;
    trc_data    = d;
    test_ending = e;
    rd_ready    = r;
  endtask

  // reference model: buffer as a queue, drain as a countdown of remaining words
  always @(posedge clk or negedge reset_n) begin
    for (int m = 0; m < 2; m++) begin
      if (!reset_n) begin
        mbuf[m].delete(); exp_q[m].delete();
        phase[m] = 0; mcnt[m] = 0; movf[m] = 0; mend[m] = 0;
      end else if (arm) begin
        mbuf[m].delete(); exp_q[m].delete();
        phase[m] = 1; mcnt[m] = 0; movf[m] = 0; mend[m] = 0;
      end else begin
        case (phase[m])
          1: begin
            if (trc_valid) begin
              if (mbuf[m].size() < DEP) mbuf[m].push_back(trc_data);
              else begin
                movf[m] = 1;
                if (m == 1) begin
                  void'(mbuf[m].pop_front());
                  mbuf[m].push_back(trc_data);
                end
              end
            end
            mcnt[m] = mbuf[m].size();
            if (test_ending) begin
              phase[m] = 2;
              exp_q[m] = mbuf[m];
            end
          end
          2: begin
            if (mcnt[m] == 0) begin
              phase[m] = 3; mend[m] = 1;
            end else if (rd_ready) begin
              mcnt[m]--;
              if (mcnt[m] == 0) begin
                phase[m] = 3; mend[m] = 1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // monitor: compare flags every cycle, pop the scoreboard on each handshake
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      checkOutput($sformatf("state[%0d]", m), 32'(state_o[m]), 32'(phase[m]));
      checkOutput($sformatf("trc_count[%0d]", m), 32'(count_o[m]), 32'(mcnt[m]));
      checkOutput($sformatf("overflow[%0d]", m), 32'(ovf_o[m]), 32'(movf[m]));
      checkOutput($sformatf("test_has_ended[%0d]", m), 32'(ended_o[m]), 32'(mend[m]));
      checkOutput($sformatf("rd_valid[%0d]", m), 32'(rd_valid_o[m]),
                  32'((phase[m] == 2) && (mcnt[m] != 0)));
      if (rd_valid_o[m]) begin
        if (exp_q[m].size() == 0) begin
          n_checks++;
          n_errors++;
          $display("[TB] FAIL scoreboard[%0d]: got word 0x%0h, expected no word", m, rd_data_o[m]);
        end else begin
          checkOutput($sformatf("rd_data[%0d]", m), 32'(rd_data_o[m]), 32'(exp_q[m][0]));
          if (rd_ready && !arm) void'(exp_q[m].pop_front());
        end
      end else begin
        checkOutput($sformatf("rd_data_idle[%0d]", m), 32'(rd_data_o[m]), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    int n;
    reset_n = 1'b0; arm = 1'b0; trc_valid = 1'b0; trc_data = '0;
    test_ending = 1'b0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // writes without arm are ignored
    $display("[TB] idle writes");
    repeat (5) applyStimulus(0, 1, DW'($urandom), 0, 1);
    applyStimulus(0, 0, '0, 0, 0);
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      checkOutput("t1_state", 32'(state_o[m]), 32'd0);
      checkOutput("t1_count", 32'(count_o[m]), 32'd0);
    end

    // six writes into a four-deep buffer, then drain
    $display("[TB] stop and wrap fill");
    applyStimulus(1, 0, '0, 0, 0);
    for (int i = 1; i <= 6; i++) applyStimulus(0, 1, DW'(i), 0, 0);
    applyStimulus(0, 0, '0, 1, 0);
    applyStimulus(0, 0, '0, 0, 1);
    @(negedge clk);
    checkOutput("t2_count", 32'(count_o[0]), 32'd4);
    checkOutput("t2_ovf", 32'(ovf_o[0]), 32'd1);
    checkOutput("t2_first", 32'(rd_data_o[0]), 32'h1);
    checkOutput("t3_first", 32'(rd_data_o[1]), 32'h3);
    checkOutput("t3_ovf", 32'(ovf_o[1]), 32'd1);
    repeat (3) applyStimulus(0, 0, '0, 0, 1);
    @(negedge clk);
    checkOutput("t2_last", 32'(rd_data_o[0]), 32'h4);
    checkOutput("t3_last", 32'(rd_data_o[1]), 32'h6);
    checkOutput("t2_not_ended", 32'(ended_o[0]), 32'd0);
    applyStimulus(0, 0, '0, 0, 0);
    @(negedge clk);
    checkOutput("t2_ended", 32'(ended_o[0]), 32'd1);
    checkOutput("t3_done_count", 32'(count_o[1]), 32'd0);
    checkOutput("t3_done_state", 32'(state_o[1]), 32'd3);

    // empty drain
    $display("[TB] empty drain");
    applyStimulus(1, 0, '0, 0, 0);
    applyStimulus(0, 0, '0, 1, 1);
    applyStimulus(0, 0, '0, 0, 1);
    @(negedge clk);
    checkOutput("t4_drain", 32'(state_o[0]), 32'd2);
    checkOutput("t4_valid", 32'(rd_valid_o[0]), 32'd0);
    applyStimulus(0, 0, '0, 0, 0);
    @(negedge clk);
    checkOutput("t4_done", 32'(state_o[0]), 32'd3);
    checkOutput("t4_ended", 32'(ended_o[0]), 32'd1);

    // write coincident with test_ending, back-pressured drain
    $display("[TB] last word with test_ending");
    applyStimulus(1, 0, '0, 0, 0);
    applyStimulus(0, 1, DW'(32'h11), 0, 0);
    applyStimulus(0, 1, DW'(32'h22), 0, 0);
    applyStimulus(0, 1, DW'(32'h2A), 1, 0);
    applyStimulus(0, 0, '0, 0, 1);
    applyStimulus(0, 0, '0, 0, 0);
    @(negedge clk);
    checkOutput("t5_hold_a", 32'(rd_data_o[0]), 32'h22);
    applyStimulus(0, 0, '0, 0, 0);
    @(negedge clk);
    checkOutput("t5_hold_b", 32'(rd_data_o[0]), 32'h22);
    applyStimulus(0, 0, '0, 0, 1);
    applyStimulus(0, 0, '0, 0, 1);
    @(negedge clk);
    checkOutput("t5_last", 32'(rd_data_o[0]), 32'h2A);
    applyStimulus(0, 0, '0, 0, 0);
    @(negedge clk);
    checkOutput("t5_done", 32'(state_o[0]), 32'd3);

    // async reset mid-drain
    $display("[TB] reset mid-drain");
    applyStimulus(1, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, DW'($urandom), 0, 0);
    applyStimulus(0, 0, '0, 1, 0);
    applyStimulus(0, 0, '0, 0, 0);
    @(negedge clk);
    checkOutput("t6_count", 32'(count_o[0]), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      checkOutput("t6_rst_state", 32'(state_o[m]), 32'd0);
      checkOutput("t6_rst_count", 32'(count_o[m]), 32'd0);
      checkOutput("t6_rst_valid", 32'(rd_valid_o[m]), 32'd0);
      checkOutput("t6_rst_data", 32'(rd_data_o[m]), 32'd0);
      checkOutput("t6_rst_ovf", 32'(ovf_o[m]), 32'd0);
      checkOutput("t6_rst_ended", 32'(ended_o[m]), 32'd0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    applyStimulus(1, 0, '0, 0, 0);
    applyStimulus(0, 1, DW'(32'h5), 0, 0);
    applyStimulus(0, 0, '0, 0, 0);
    @(negedge clk);
    checkOutput("t6_count_after", 32'(count_o[0]), 32'd1);
    checkOutput("t6_ended_after", 32'(ended_o[0]), 32'd0);

    // randomized capture/drain rounds
    $display("[TB] random rounds");
    for (int r = 0; r < 25; r++) begin
      applyStimulus(1, 0, '0, 0, 0);
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) applyStimulus(0, 1'($urandom), DW'($urandom), 0, 0);
      applyStimulus(0, 1'($urandom), DW'($urandom), 1, 0);
      guard = 0;
      while (!(phase[0] == 3 && phase[1] == 3) && guard < 60) begin
        applyStimulus(0, 1'($urandom), DW'($urandom), 1'($urandom), 1'($urandom));
        guard++;
        if ((r % 6) == 5 && guard == 2) begin
          applyStimulus(1, 0, '0, 0, 0);
          break;
        end
      end
      if (guard >= 60) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL drain_timeout: got no DONE after %0d cycles, expected DONE", guard);
      end
    end

    applyStimulus(0, 0, '0, 0, 0);
    applyStimulus(0, 0, '0, 0, 0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
